datapath_pipe: RTL and testbench

- Two-stage pipelined successor to the single-cycle datapath.
- Contains an internal 2^M x N register file, an operand-select stage and a registered ALU/flag stage.
- Adds a valid/ready instruction handshake and a read-after-write hazard interlock.
- Sits between the controller/sequencer and the memory address/data buses.

---
 rtl/datapath_pipe.sv | 131 +++++++++++++
 tb/tb_datapath_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// Two-stage pipelined datapath: operand-select (ID) stage feeding a registered ALU/flag result stage.
// Define DATAPATH_PIPE_FWD_EN to forward hazard operands instead of stalling for one cycle.
module datapath_pipe #(
  parameter int M = 3,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [M-1:0] ra,
  input  logic [M-1:0] rb,
  input  logic [M-1:0] waddr,
  input  logic         write,
  input  logic         ie,
  input  logic [N-1:0] din,
  input  logic         bypassa,
  input  logic [N-1:0] offset,
  input  logic         flag_en,
  input  logic         oe,
  input  logic         data_en,
  input  logic         addr_en,
  output logic         out_valid,
  output logic [N-1:0] dout,
  output logic [N-1:0] addr,
  output logic         o_flag,
  output logic         z_flag,
  output logic         n_flag
);
  localparam int R = 1 << M;

  logic [N-1:0] rf [R];

  logic         id_valid, id_write, id_ie, id_flag_en, id_oe, id_data_en, id_addr_en;
  logic [2:0]   id_op;
  logic [M-1:0] id_waddr;
  logic [N-1:0] id_a, id_b, id_din;

  logic [N-1:0] alu, result, opa, opb;
  logic         alu_ovf, haz_a, haz_b, accept;

  always_comb begin
    alu     = '0;
    alu_ovf = 1'b0;
    case (id_op)
      3'b000: begin
        alu     = id_a + id_b;
        alu_ovf = (id_a[N-1] == id_b[N-1]) && (alu[N-1] != id_a[N-1]);
      end
      3'b001: begin
        alu     = id_a - id_b;
        alu_ovf = (id_a[N-1] != id_b[N-1]) && (alu[N-1] != id_a[N-1]);
      end
      3'b010: alu = id_a & id_b;
      3'b011: alu = id_a | id_b;
      3'b100: alu = id_a ^ id_b;
      3'b101: alu = ~id_a;
      3'b110: alu = id_b;
      default: begin
        alu     = id_a + N'(1);
        alu_ovf = alu[N-1] & ~id_a[N-1];
      end
    endcase
    result = id_ie ? id_din : alu;
  end

  // An RF read at the same edge as the ID-stage write would see the stale value.
  assign haz_a = id_valid & id_write & ~bypassa & (ra == id_waddr);
  assign haz_b = id_valid & id_write & (rb == id_waddr);

`ifdef DATAPATH_PIPE_FWD_EN
  assign in_ready = rst;
  assign opa      = bypassa ? offset : (haz_a ? result : rf[ra]);
  assign opb      = haz_b ? result : rf[rb];
`else
  assign in_ready = rst & ~(in_valid & (haz_a | haz_b));
  assign opa      = bypassa ? offset : rf[ra];
  assign opb      = rf[rb];
`endif

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < R; i++) rf[i] <= '0;
      id_valid   <= 1'b0;
      id_write   <= 1'b0;
      id_ie      <= 1'b0;
      id_flag_en <= 1'b0;
      id_oe      <= 1'b0;
      id_data_en <= 1'b0;
      id_addr_en <= 1'b0;
      id_op      <= '0;
      id_waddr   <= '0;
      id_a       <= '0;
      id_b       <= '0;
      id_din     <= '0;
      out_valid  <= 1'b0;
      dout       <= '0;
      addr       <= '0;
      o_flag     <= 1'b0;
      z_flag     <= 1'b0;
      n_flag     <= 1'b0;
    end else begin
      id_valid <= accept;
      if (accept) begin
        id_write   <= write;
        id_ie      <= ie;
        id_flag_en <= flag_en;
        id_oe      <= oe;
        id_data_en <= data_en;
        id_addr_en <= addr_en;
        id_op      <= op;
        id_waddr   <= waddr;
        id_a       <= opa;
        id_b       <= opb;
        id_din     <= din;
      end
      out_valid <= id_valid;
      dout      <= (id_valid & id_oe & id_data_en) ? result : '0;
      addr      <= (id_valid & id_oe & id_addr_en) ? result : '0;
      if (id_valid & id_write) rf[id_waddr] <= result;
      if (id_valid & id_flag_en & ~id_ie) begin
        o_flag <= alu_ovf;
        z_flag <= (result == '0);
        n_flag <= result[N-1];
      end
    end
  end
endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: sequential instruction-level model plus directed literal checks.
// Honours DATAPATH_PIPE_FWD_EN when deciding the expected in_ready / bubble behaviour.
module tb_datapath_pipe;
  localparam int M = 3;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [2:0]   op;
  logic [M-1:0] ra, rb, waddr;
  logic         write, ie, bypassa, flag_en, oe, data_en, addr_en;
  logic [N-1:0] din, offset;
  logic         out_valid;
  logic [N-1:0] dout, addr;
  logic         o_flag, z_flag, n_flag;

  datapath_pipe #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ra(ra), .rb(rb), .waddr(waddr), .write(write), .ie(ie),
    .din(din), .bypassa(bypassa), .offset(offset), .flag_en(flag_en),
    .oe(oe), .data_en(data_en), .addr_en(addr_en),
    .out_valid(out_valid), .dout(dout), .addr(addr),
    .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  ra, rb, waddr;
    logic        write, ie, bypassa, flag_en, oe, data_en, addr_en;
    logic [15:0] din, offset;
  } ins_t;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model: instructions take effect in program order at accept time.
  logic [15:0] mrf [8];
  bit          pend_valid;
  ins_t        pend;
  logic [15:0] pend_res;
  bit          pend_fu, pend_o, pend_z, pend_n;
  bit          exp_valid, exp_o, exp_z, exp_n;
  logic [15:0] exp_dout, exp_addr;
  logic [15:0] last_dout, last_addr;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    pend_valid = 0; pend_fu = 0;
    exp_valid = 0; exp_dout = '0; exp_addr = '0;
    exp_o = 0; exp_z = 0; exp_n = 0;
  endtask

  task automatic execute(input ins_t i);
    logic [15:0] a, b, r, res;
    int sa, sb, sr;
    bit ovf;
    a = i.bypassa ? i.offset : mrf[i.ra];
    b = mrf[i.rb];
    sa = int'($signed(a));
    sb = int'($signed(b));
    ovf = 0;
    case (i.op)
      3'd0: begin sr = sa + sb; r = a + b; ovf = (sr > 32767) || (sr < -32768); end
      3'd1: begin sr = sa - sb; r = a - b; ovf = (sr > 32767) || (sr < -32768); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = b;
      default: begin sr = sa + 1; r = a + 16'd1; ovf = (sr > 32767); end
    endcase
    res = i.ie ? i.din : r;
    pend = i;
    pend_res = res;
    pend_fu = i.flag_en && !i.ie;
    pend_o = ovf;
    pend_z = (res == 16'd0);
    pend_n = res[15];
    if (i.write) mrf[i.waddr] = res;
  endtask

  task automatic model_edge(input bit acc, input ins_t i);
    exp_valid = pend_valid;
    exp_dout = (pend_valid && pend.oe && pend.data_en) ? pend_res : 16'd0;
    exp_addr = (pend_valid && pend.oe && pend.addr_en) ? pend_res : 16'd0;
    if (pend_valid && pend_fu) begin exp_o = pend_o; exp_z = pend_z; exp_n = pend_n; end
    pend_valid = acc;
    if (acc) execute(i);
  endtask

  function automatic bit exp_ready_f(input ins_t i, input bit v);
`ifdef DATAPATH_PIPE_FWD_EN
    return 1'b1;
`else
    if (!v || !pend_valid || !pend.write) return 1'b1;
    return !((!i.bypassa && i.ra == pend.waddr) || (i.rb == pend.waddr));
`endif
  endfunction

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.op = 3'($urandom); i.ra = 3'($urandom); i.rb = 3'($urandom); i.waddr = 3'($urandom);
    i.write = 1'($urandom); i.ie = ($urandom_range(0, 3) == 0); i.bypassa = ($urandom_range(0, 3) == 0);
    i.flag_en = 1'($urandom); i.oe = ($urandom_range(0, 3) != 0);
    i.data_en = 1'($urandom); i.addr_en = 1'($urandom);
    i.din = rand_data(); i.offset = rand_data();
    return i;
  endfunction

  function automatic ins_t ld(input logic [2:0] wa, input logic [15:0] v);
    ins_t i = rand_ins();
    i.ie = 1; i.write = 1; i.waddr = wa; i.din = v; i.ra = 0; i.rb = 0;
    i.bypassa = 0; i.flag_en = 0; i.oe = 0;
    return i;
  endfunction

  function automatic ins_t alu_i(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                                 input logic [2:0] wa, input bit wr, input bit fe);
    ins_t i = rand_ins();
    i.op = o; i.ra = a; i.rb = b; i.waddr = wa; i.write = wr; i.flag_en = fe;
    i.ie = 0; i.bypassa = 0; i.oe = 1; i.data_en = 1; i.addr_en = 0;
    return i;
  endfunction

  // Compare process: registered outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 16'(out_valid), 16'(exp_valid));
      chk("dout", dout, exp_dout);
      chk("addr", addr, exp_addr);
      chk("flags_ozn", {13'd0, o_flag, z_flag, n_flag}, {13'd0, exp_o, exp_z, exp_n});
      if (out_valid) begin last_dout = dout; last_addr = addr; end
    end
  end

  task automatic cycle(input bit v, input ins_t i, output bit acc);
    bit er;
    @(negedge clk);
    in_valid = v; op = i.op; ra = i.ra; rb = i.rb; waddr = i.waddr;
    write = i.write; ie = i.ie; din = i.din; bypassa = i.bypassa; offset = i.offset;
    flag_en = i.flag_en; oe = i.oe; data_en = i.data_en; addr_en = i.addr_en;
    #1;
    er = exp_ready_f(i, v);
    chk("in_ready", 16'(in_ready), 16'(er));
    acc = v && er;
    @(posedge clk);
    model_edge(acc, i);
  endtask

  task automatic issue(input ins_t i, output int tries);
    bit acc;
    tries = 0;
    do begin cycle(1'b1, i, acc); tries++; end while (!acc && tries < 4);
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: got not-accepted expected accepted within 4 cycles at %0t", $time);
    end
    $display("issue op=%0d ra=%0d rb=%0d wa=%0d wr=%0d ie=%0d tries=%0d", i.op, i.ra, i.rb, i.waddr, i.write, i.ie, tries);
  endtask

  task automatic idle(input int n);
    bit acc;
    ins_t z = rand_ins();
    repeat (n) cycle(1'b0, z, acc);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 0;
    in_valid = 0;
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_dout", dout, 16'd0);
    chk("rst_addr", addr, 16'd0);
    chk("rst_flags", {13'd0, o_flag, z_flag, n_flag}, 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
  endtask

  initial begin
    ins_t i;
    int t;
    bit acc;
    rst = 0; in_valid = 0;
    i = rand_ins();
    op = i.op; ra = 0; rb = 0; waddr = 0; write = 0; ie = 0; din = 0; bypassa = 0;
    offset = 0; flag_en = 0; oe = 0; data_en = 0; addr_en = 0;
    model_reset();
    last_dout = '0; last_addr = '0;
    #12;
    chk("init_out_valid", 16'(out_valid), 16'd0);
    chk("init_flags", {13'd0, o_flag, z_flag, n_flag}, 16'd0);
    rst = 1;
    chk_en = 1;

    // Load / add
    issue(ld(3'd1, 16'h0005), t);
    issue(ld(3'd2, 16'h0003), t);
    issue(alu_i(3'd0, 3'd1, 3'd2, 3'd5, 1'b0, 1'b1), t);
    idle(2);
    chk("add_dout", last_dout, 16'h0008);
    chk("add_flags", {13'd0, o_flag, z_flag, n_flag}, 16'h0000);

    // Overflow on increment, flag hold, then zero from subtract
    issue(ld(3'd1, 16'h7FFF), t);
    issue(alu_i(3'd7, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1), t);
    idle(2);
    chk("inc_dout", last_dout, 16'h8000);
    chk("inc_flags", {13'd0, o_flag, z_flag, n_flag}, 16'h0005);
    issue(alu_i(3'd2, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0), t);
    idle(2);
    chk("hold_dout", last_dout, 16'h0000);
    chk("hold_flags", {13'd0, o_flag, z_flag, n_flag}, 16'h0005);
    issue(alu_i(3'd1, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1), t);
    idle(2);
    chk("sub_dout", last_dout, 16'h0000);
    chk("sub_flags", {13'd0, o_flag, z_flag, n_flag}, 16'h0002);

    // Back-to-back read-after-write
    issue(ld(3'd1, 16'h0002), t);
    issue(ld(3'd2, 16'h0005), t);
    issue(alu_i(3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0), t);
    issue(alu_i(3'd0, 3'd3, 3'd3, 3'd4, 1'b1, 1'b0), t);
`ifdef DATAPATH_PIPE_FWD_EN
    chk("hazard_tries", 16'(t), 16'd1);
`else
    chk("hazard_tries", 16'(t), 16'd2);
`endif
    issue(alu_i(3'd6, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0), t);
    idle(2);
    chk("hazard_r4", last_dout, 16'h000E);

    // Bypass operand A with address enable, then outputs gated by oe=0
    i = alu_i(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    i.bypassa = 1; i.offset = 16'h0100; i.data_en = 0; i.addr_en = 1;
    issue(i, t);
    idle(2);
    chk("bypass_addr", last_addr, 16'h0100);
    chk("bypass_dout", last_dout, 16'h0000);
    i.oe = 0; i.data_en = 1;
    issue(i, t);
    idle(2);
    chk("oe0_addr", last_addr, 16'h0000);
    chk("oe0_dout", last_dout, 16'h0000);

    // Mid-stream reset loses the pending write
    issue(ld(3'd5, 16'h1234), t);
    do_reset();
    for (int r = 0; r < 8; r++) begin
      last_dout = 16'hDEAD;
      issue(alu_i(3'd6, 3'd0, 3'(r), 3'd0, 1'b0, 1'b0), t);
      idle(2);
      chk("post_rst_rf", last_dout, 16'h0000);
    end

    // Randomized traffic with one reset in the middle
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 3) != 0, rand_ins(), acc);
      if (k == 1500) do_reset();
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
